store_buffer: RTL and testbench

- Write-side counterpart of the load extension path in the RV32I pipeline.
- Accepts stores from the MEM stage: sb, sh and sw (funct3 000, 001, 010).
- Steers the store data onto byte lanes and generates 4-bit byte strobes.
- Queues the aligned word writes in a small FIFO and drains them to data memory over a valid/ready port, so memory stalls do not immediately stall the pipeline.

---
 rtl/store_pkg.sv | 14 +
 rtl/store_buffer_if.sv | 15 +
 rtl/store_align.sv | 38 +++
 rtl/store_buffer.sv | 117 +++++++++++
 tb/tb_store_buffer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared store-buffer types: funct3 store encodings and the buffered word-write entry.
package store_pkg;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  strb;
    } store_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Word-write port from the store buffer to data memory (valid/ready handshake).
interface store_buffer_if;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    modport master (output mem_valid, output mem_addr, output mem_wdata, output mem_wstrb,
                    input  mem_ready);
    modport slave  (input  mem_valid, input  mem_addr, input  mem_wdata, input  mem_wstrb,
                    output mem_ready);

endinterface

// File: rtl/store_align.sv
// Write-side mirror of load extension: lane steering, byte strobes and misalignment check.
module store_align
    import store_pkg::*;
(
    input  logic [2:0]   store_type,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    output logic         legal,
    output logic         misaligned,
    output store_entry_t entry
);

    always_comb begin
        legal       = 1'b1;
        misaligned  = 1'b0;
        entry.waddr = addr[31:2];
        entry.data  = wdata;
        entry.strb  = 4'b1111;
        case (store_type)
            SB: begin
                entry.data = {4{wdata[7:0]}};
                entry.strb = 4'b0001 << addr[1:0];
            end
            SH: begin
                entry.data = {2{wdata[15:0]}};
                entry.strb = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            SW: begin
                misaligned = (addr[1:0] != 2'b00);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// RV32I store buffer: aligns sb/sh/sw and queues word writes to data memory in a FIFO.
// Optional load forwarding lookup is built only when STORE_FWD_EN is defined.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StoreValidM,
    input  logic [2:0]            StoreTypeM,
    input  logic [31:0]           ALUResultM,
    input  logic [31:0]           WriteDataM,
    output logic                  store_ready,
    output logic                  misaligned,
    output logic                  empty,
    input  logic [31:0]           ld_addr,
    output logic                  fwd_hit,
    output logic [31:0]           fwd_data,
    output logic [3:0]            fwd_mask,
    store_buffer_if.master        mem
);

    localparam int AW = $clog2(DEPTH);

    store_entry_t         entries [DEPTH];
    store_entry_t         new_entry;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 legal;
    logic                 addr_misaligned;
    logic                 push;
    logic                 pop;
    logic                 misaligned_q;

    store_align u_align (
        .store_type (StoreTypeM),
        .addr       (ALUResultM),
        .wdata      (WriteDataM),
        .legal      (legal),
        .misaligned (addr_misaligned),
        .entry      (new_entry)
    );

    assign full        = (count == (AW+1)'(DEPTH));
    assign empty       = (count == '0);
    assign store_ready = !full;

    // A pop in the same cycle never frees space for a push when full.
    assign push = StoreValidM && store_ready && legal && !addr_misaligned;
    assign pop  = mem.mem_valid && mem.mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            misaligned_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            misaligned_q <= StoreValidM && legal && addr_misaligned;
            if (push) begin
                entries[wr_ptr] <= new_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign misaligned    = misaligned_q;
    assign mem.mem_valid = !empty;
    assign mem.mem_addr  = {entries[rd_ptr].waddr, 2'b00};
    assign mem.mem_wdata = entries[rd_ptr].data;
    assign mem.mem_wstrb = entries[rd_ptr].strb;

`ifdef STORE_FWD_EN
    logic [AW-1:0] idx;
    logic          unused_ld;

    assign unused_ld = ^ld_addr[1:0];

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_mask = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + AW'(k);
            if (((AW+1)'(k) < count) && (entries[idx].waddr == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
                fwd_mask = entries[idx].strb;
            end
        end
    end
`else
    logic unused_ld;

    assign unused_ld = ^ld_addr;
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign fwd_mask  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4); forwarding checks follow STORE_FWD_EN.
module tb_store_buffer;
    import store_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        StoreValidM;
    logic [2:0]  StoreTypeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        store_ready;
    logic        misaligned;
    logic        empty;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_mask;

    int checks = 0;
    int errors = 0;

    store_buffer_if mif();

    store_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .StoreValidM (StoreValidM),
        .StoreTypeM  (StoreTypeM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .store_ready (store_ready),
        .misaligned  (misaligned),
        .empty       (empty),
        .ld_addr     (ld_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .fwd_mask    (fwd_mask),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        StoreValidM = 1'b1;
        StoreTypeM  = t;
        ALUResultM  = a;
        WriteDataM  = d;
        tick();
        StoreValidM = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int n;
        vecs[0] = '{SB, 32'h0000_1003, 32'hAABB_CCDD, 32'hDDDD_DDDD, 4'b1000};
        vecs[1] = '{SH, 32'h0000_2002, 32'h0000_1234, 32'h1234_1234, 4'b1100};
        vecs[2] = '{SB, 32'h0000_1002, 32'h0000_005A, 32'h5A5A_5A5A, 4'b0100};
        vecs[3] = '{SH, 32'h0000_2000, 32'hFFFF_BEEF, 32'hBEEF_BEEF, 4'b0011};
        vecs[4] = '{SW, 32'h0000_2004, 32'h1357_9BDF, 32'h1357_9BDF, 4'b1111};

        reset         = 1'b1;
        StoreValidM   = 1'b0;
        StoreTypeM    = SW;
        ALUResultM    = '0;
        WriteDataM    = '0;
        ld_addr       = '0;
        mif.mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", store_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_valid", mif.mem_valid, 0);
        chk("rst_mis", misaligned, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        chk("rst_wstrb", mif.mem_wstrb, 0);
        chk("rst_fwd", {fwd_hit, fwd_mask}, 0);

        // single stores, each visible one cycle after acceptance then popped
        mif.mem_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].t, vecs[i].a, vecs[i].d);
            chk("lat_valid", mif.mem_valid, 1);
            chk("lat_addr", mif.mem_addr, {vecs[i].a[31:2], 2'b00});
            chk("lat_wdata", mif.mem_wdata, vecs[i].exp_data);
            chk("lat_wstrb", mif.mem_wstrb, vecs[i].exp_strb);
            tick();
            chk("pop_empty", empty, 1);
        end

        drive(SW, 32'h0000_2001, 32'h0);
        chk("mis_pulse", misaligned, 1);
        chk("mis_empty", empty, 1);
        tick();
        chk("mis_clear", misaligned, 0);
        drive(SH, 32'h0000_2003, 32'h0);
        chk("mis_sh", misaligned, 1);
        drive(3'b100, 32'h0000_2001, 32'h0);
        chk("illegal_mis", misaligned, 0);
        chk("illegal_empty", empty, 1);

        // stall: fill, reject 5th, check hold stability, then drain in order
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fill_ready", store_ready, 1);
            drive(SW, 32'h0000_4000 + 32'(4*i), 32'h1000_0000 + 32'(i));
        end
        chk("full_ready", store_ready, 0);
        drive(SW, 32'h0000_5000, 32'hDEAD_BEEF);
        chk("full_ready2", store_ready, 0);
        drive(SW, 32'h0000_5002, 32'h0);
        chk("full_mis", misaligned, 1);
        chk("stall_addr", mif.mem_addr, 32'h0000_4000);
        chk("stall_wdata", mif.mem_wdata, 32'h1000_0000);
        chk("stall_wstrb", mif.mem_wstrb, 4'hF);
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", mif.mem_valid, 1);
            chk("drain_addr", mif.mem_addr, 32'h0000_4000 + 32'(4*i));
            chk("drain_wdata", mif.mem_wdata, 32'h1000_0000 + 32'(i));
            tick();
        end
        chk("drain_empty", empty, 1);

        // full buffer: push with pop in same cycle is rejected
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(SW, 32'h0000_6000 + 32'(4*i), 32'h6000 + 32'(i));
        mif.mem_ready = 1'b1;
        drive(SW, 32'h0000_7000, 32'h7777_7777);
        chk("fullpop_ready", store_ready, 1);
        n = 0;
        while (mif.mem_valid && n < 10) begin
            chk("fullpop_addr", mif.mem_addr, 32'h0000_6004 + 32'(4*n));
            tick();
            n++;
        end
        chk("fullpop_cnt", n, 3);

        // half full: push with pop keeps count
        mif.mem_ready = 1'b0;
        drive(SW, 32'h0000_8000, 32'h8);
        drive(SW, 32'h0000_8004, 32'h9);
        mif.mem_ready = 1'b1;
        drive(SW, 32'h0000_8008, 32'hA);
        n = 0;
        while (mif.mem_valid && n < 10) begin
            chk("half_addr", mif.mem_addr, 32'h0000_8004 + 32'(4*n));
            tick();
            n++;
        end
        chk("half_cnt", n, 2);

        // forwarding lookup
        mif.mem_ready = 1'b0;
        drive(SB, 32'h0000_3001, 32'h0000_0011);
        drive(SW, 32'h0000_3000, 32'hCAFE_F00D);
        ld_addr = 32'h0000_3002;
        #1;
`ifdef STORE_FWD_EN
        chk("fwd_hit", fwd_hit, 1);
        chk("fwd_data", fwd_data, 32'hCAFE_F00D);
        chk("fwd_mask", fwd_mask, 4'hF);
        ld_addr = 32'h0000_3004;
        #1;
        chk("fwd_miss", fwd_hit, 0);
`else
        chk("fwd_off_hit", fwd_hit, 0);
        chk("fwd_off_data", fwd_data, 0);
        chk("fwd_off_mask", fwd_mask, 0);
`endif

        // reset with 3 pending entries and a misaligned request in flight
        drive(SB, 32'h0000_3001, 32'h0000_0022);
        chk("pre_rst_valid", mif.mem_valid, 1);
        reset       = 1'b1;
        drive(SW, 32'h0000_3001, 32'h0);
        reset = 1'b0;
        chk("rst2_empty", empty, 1);
        chk("rst2_valid", mif.mem_valid, 0);
        chk("rst2_ready", store_ready, 1);
        chk("rst2_mis", misaligned, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
